// File: rtl/isa_pkg.sv
// Shared instruction-format definitions for the decode/issue stage: field positions,
// instruction classes and the decoded-instruction record.
package isa_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_LSB = 14;

    typedef enum logic [1:0] {
        CLS_R  = 2'b00,
        CLS_I  = 2'b01,
        CLS_SB = 2'b10,
        CLS_J  = 2'b11
    } cls_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [SEL_W-1:0] rd;
        logic [SEL_W-1:0] rs1;
        logic [SEL_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic             regwr;
        logic             uses_rs1;
        logic             uses_rs2;
    } dec_t;

    // Immediate occupies the low imm_w bits and is sign-extended to XLEN.
    function automatic dec_t decode(input logic [XLEN-1:0] instr, input int unsigned imm_w);
        dec_t             d;
        cls_e             cls;
        logic [XLEN-1:0]  hi_mask;
        logic [4:0]       sign_idx;
        d.op     = instr[OP_LSB +: OP_W];
        d.rd     = instr[RD_LSB +: SEL_W];
        d.rs1    = instr[RS1_LSB +: SEL_W];
        d.rs2    = instr[RS2_LSB +: SEL_W];
        hi_mask  = {XLEN{1'b1}} << imm_w;
        sign_idx = 5'(imm_w - 1);
        d.imm    = (instr & ~hi_mask) | ({XLEN{instr[sign_idx]}} & hi_mask);
        cls      = cls_e'(d.op[OP_W-1 -: 2]);
        d.uses_rs1 = (cls != CLS_J);
        d.uses_rs2 = (cls == CLS_R) || (cls == CLS_SB);
        d.regwr    = ((cls == CLS_R) || (cls == CLS_I)) && (d.rd != '0);
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue, cleared on
// writeback (set wins on collision), with a combined RAW/WAW hazard query.
module reg_scoreboard #(
    parameter int unsigned NREGS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_set_en,
    input  logic [$clog2(NREGS)-1:0] i_set_sel,
    input  logic                     i_clr_en,
    input  logic [$clog2(NREGS)-1:0] i_clr_sel,
    input  logic                     i_rs1_en,
    input  logic [$clog2(NREGS)-1:0] i_rs1,
    input  logic                     i_rs2_en,
    input  logic [$clog2(NREGS)-1:0] i_rs2,
    input  logic                     i_rd_en,
    input  logic [$clog2(NREGS)-1:0] i_rd,
    output logic                     o_hazard,
    output logic [NREGS-1:0]         o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // R0 is hard-wired idle, so neither port may touch bit 0.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en && (i_clr_sel != '0)) begin
            w_busy_nxt[i_clr_sel] = 1'b0;
        end
        if (i_set_en && (i_set_sel != '0)) begin
            w_busy_nxt[i_set_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_hazard = (i_rs1_en & r_busy[i_rs1])
                    | (i_rs2_en & r_busy[i_rs2])
                    | (i_rd_en  & r_busy[i_rd]);
    assign o_busy   = r_busy;

endmodule

// File: rtl/decode_issue.sv
// Decode and issue stage: holds one instruction until its operands are free, then moves it
// into a registered valid/ready output that drives the register-file selectors.
module decode_issue
    import isa_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned IMM_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             wb_valid,
    input  logic [3:0]       wb_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_op,
    output logic [3:0]       out_rd,
    output logic [3:0]       out_rs1,
    output logic [3:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic             out_regwr,
    output logic [NREGS-1:0] busy
);

    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_out_valid;
    logic [5:0]  r_out_op;
    logic [3:0]  r_out_rd;
    logic [3:0]  r_out_rs1;
    logic [3:0]  r_out_rs2;
    logic [31:0] r_out_imm;
    logic        r_out_regwr;

    dec_t        w_dec;
    logic        w_hazard;
    logic        w_issue;
    logic        w_accept;

    assign w_dec    = decode(r_ir, IMM_W);
    assign w_issue  = r_ir_valid & ~w_hazard & (~r_out_valid | out_ready);
    assign in_ready = ~r_ir_valid | w_issue;
    assign w_accept = in_valid & in_ready;

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set_en  (w_issue & w_dec.regwr),
        .i_set_sel (w_dec.rd),
        .i_clr_en  (wb_valid),
        .i_clr_sel (wb_rd),
        .i_rs1_en  (w_dec.uses_rs1),
        .i_rs1     (w_dec.rs1),
        .i_rs2_en  (w_dec.uses_rs2),
        .i_rs2     (w_dec.rs2),
        .i_rd_en   (w_dec.regwr),
        .i_rd      (w_dec.rd),
        .o_hazard  (w_hazard),
        .o_busy    (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_accept) begin
            r_ir       <= in_instr;
            r_ir_valid <= 1'b1;
        end else if (w_issue) begin
            r_ir_valid <= 1'b0;
        end
    end

    // Output fields only change on issue, so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_out_rd    <= '0;
            r_out_rs1   <= '0;
            r_out_rs2   <= '0;
            r_out_imm   <= '0;
            r_out_regwr <= 1'b0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_op    <= w_dec.op;
            r_out_rd    <= w_dec.rd;
            r_out_rs1   <= w_dec.rs1;
            r_out_rs2   <= w_dec.rs2;
            r_out_imm   <= w_dec.imm;
            r_out_regwr <= w_dec.regwr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_op    = r_out_op;
    assign out_rd    = r_out_rd;
    assign out_rs1   = r_out_rs1;
    assign out_rs2   = r_out_rs2;
    assign out_imm   = r_out_imm;
    assign out_regwr = r_out_regwr;

endmodule
